// File: rtl/rglib_rotate_mon_pkg.sv
// Shared types and constants for the rotate-datapath stream monitor.
package rglib_rotate_mon_pkg;

   // Widest counter / latency a monitor instance may be configured with.
   // Per-channel stats travel in fixed-width fields. A channel zero-extends
   // its values into these fields and the readout truncates them back.
   localparam int CNT_W_MAX = 64;
   localparam int LAT_W_MAX = 32;

   // Error-bit positions in the err vectors.
   localparam int ERR_UNDERFLOW = 0;
   localparam int ERR_OVERFLOW  = 1;
   localparam int ERR_RETRACT   = 2;
   localparam int ERR_W         = 3;

   // lat_min value meaning "no latency recorded yet".
   localparam logic [LAT_W_MAX-1:0] LAT_NONE_MIN = '1;

   typedef struct packed {
      logic [CNT_W_MAX-1:0] in_cnt;
      logic [CNT_W_MAX-1:0] out_cnt;
      logic [LAT_W_MAX-1:0] lat_min;
      logic [LAT_W_MAX-1:0] lat_max;
      logic [LAT_W_MAX-1:0] lat_last;
   } ch_stats_t;

endpackage

// File: rtl/rglib_rotate_mon_ch.sv
// One monitored channel: timestamp FIFO, handshake counters, latency stats
// and sticky protocol-error bits.
module rglib_rotate_mon_ch
   import rglib_rotate_mon_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CNT_W = 32,
   parameter int LAT_W = 16,
   localparam int OUT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             in_valid,
   input  logic             in_ready,
   input  logic             out_valid,
   input  logic             out_ready,
   input  logic [LAT_W-1:0] ts_now,
   output ch_stats_t        stats,
   output logic [OUT_W-1:0] outstanding,
   output logic [ERR_W-1:0] err
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [LAT_W-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [OUT_W-1:0] count_q;
   logic [CNT_W-1:0] in_cnt_q;
   logic [CNT_W-1:0] out_cnt_q;
   logic [LAT_W-1:0] lat_min_q;
   logic [LAT_W-1:0] lat_max_q;
   logic [LAT_W-1:0] lat_last_q;
   logic [ERR_W-1:0] err_q;
   logic             stall_q;

   logic             in_hs;
   logic             out_hs;
   logic             push;
   logic             pop;
   logic [LAT_W-1:0] lat;

   // Handshake decode and push/pop arbitration against the pre-cycle fill level.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
      in_hs  = in_valid & in_ready;
      out_hs = out_valid & out_ready;
      pop    = 1'b0;
      push   = 1'b0;
      lat    = ts_now - mem[rd_ptr];
      if (out_hs && (count_q != '0)) pop = 1'b1;
      if (in_hs && ((count_q < OUT_W'(DEPTH)) || pop)) push = 1'b1;
   end

   // Timestamp storage; push-time values only.
   always_ff @(posedge clk) begin
      // NOTE: storage array has no reset; pointers and count define which entries are live.
      if (push) mem[wr_ptr] <= ts_now;
   end

   // FIFO control, counters, latency stats and sticky errors.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         in_cnt_q   <= '0;
         out_cnt_q  <= '0;
         lat_min_q  <= LAT_NONE_MIN[LAT_W-1:0];
         lat_max_q  <= '0;
         lat_last_q <= '0;
         err_q      <= '0;
         stall_q    <= 1'b0;
      end else begin
         if (push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
         if (pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + OUT_W'(1);
            2'b01:   count_q <= count_q - OUT_W'(1);
            default: count_q <= count_q;
         endcase

         if (out_hs && !pop)        err_q[ERR_UNDERFLOW] <= 1'b1;
         if (in_hs && !push)        err_q[ERR_OVERFLOW]  <= 1'b1;
         if (stall_q && !out_valid) err_q[ERR_RETRACT]   <= 1'b1;
         stall_q <= out_valid & ~out_ready;

         if (clear) begin
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            lat_min_q  <= LAT_NONE_MIN[LAT_W-1:0];
            lat_max_q  <= '0;
            lat_last_q <= '0;
         end else begin
            if (in_hs && (in_cnt_q != '1))   in_cnt_q  <= in_cnt_q + CNT_W'(1);
            if (out_hs && (out_cnt_q != '1)) out_cnt_q <= out_cnt_q + CNT_W'(1);
            if (pop) begin
               lat_last_q <= lat;
               if (lat < lat_min_q) lat_min_q <= lat;
               if (lat > lat_max_q) lat_max_q <= lat;
            end
         end
      end
   end

   // Pack stats into the shared wide record.
   always_comb begin
      stats          = '0;
      stats.in_cnt   = CNT_W_MAX'(in_cnt_q);
      stats.out_cnt  = CNT_W_MAX'(out_cnt_q);
      stats.lat_min  = LAT_W_MAX'(lat_min_q);
      stats.lat_max  = LAT_W_MAX'(lat_max_q);
      stats.lat_last = LAT_W_MAX'(lat_last_q);
   end

   assign outstanding = count_q;
   assign err         = err_q;

endmodule

// File: rtl/rglib_rotate_stream_monitor.sv
// Multi-channel handshake monitor: shared timestamp, reset-activity capture,
// error OR and registered channel-select readout.
module rglib_rotate_stream_monitor
   import rglib_rotate_mon_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int DEPTH  = 8,
   parameter int CNT_W  = 32,
   parameter int LAT_W  = 16,
   localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int OUT_W = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic [NUM_CH-1:0] in_valid,
   input  logic [NUM_CH-1:0] in_ready,
   input  logic [NUM_CH-1:0] out_valid,
   input  logic [NUM_CH-1:0] out_ready,
   input  logic [SEL_W-1:0]  ch_sel,
   output logic [CNT_W-1:0]  in_cnt,
   output logic [CNT_W-1:0]  out_cnt,
   output logic [OUT_W-1:0]  outstanding,
   output logic [LAT_W-1:0]  lat_min,
   output logic [LAT_W-1:0]  lat_max,
   output logic [LAT_W-1:0]  lat_last,
   output logic [ERR_W-1:0]  err,
   output logic [1:0]        rst_activity
);

   logic [LAT_W-1:0] ts_q;
   logic             reset_q;

   ch_stats_t        stats_arr [NUM_CH];
   logic [OUT_W-1:0] outst_arr [NUM_CH];
   logic [ERR_W-1:0] err_arr   [NUM_CH];

   ch_stats_t        sel_stats;
   logic [OUT_W-1:0] sel_outst;
   logic [ERR_W-1:0] err_any;
   logic             unused_sel_bits;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      rglib_rotate_mon_ch #(
         .DEPTH (DEPTH),
         .CNT_W (CNT_W),
         .LAT_W (LAT_W)
      ) u_ch (
         .clk         (clk),
         .reset       (reset),
         .clear       (clear),
         .in_valid    (in_valid[g]),
         .in_ready    (in_ready[g]),
         .out_valid   (out_valid[g]),
         .out_ready   (out_ready[g]),
         .ts_now      (ts_q),
         .stats       (stats_arr[g]),
         .outstanding (outst_arr[g]),
         .err         (err_arr[g])
      );
   end

   // Free-running timestamp; latencies are taken modulo 2^LAT_W.
   always_ff @(posedge clk) begin
      if (reset) ts_q <= '0;
      else       ts_q <= ts_q + LAT_W'(1);
   end

   // Valid activity seen while in reset; restarts on each reset's first cycle.
   always_ff @(posedge clk) begin
      reset_q <= reset;
      if (reset) begin
         if (!reset_q) rst_activity <= {|out_valid, |in_valid};
         else          rst_activity <= rst_activity | {|out_valid, |in_valid};
      end
   end

   // Channel select (out-of-range selects channel 0) and error OR.
   always_comb begin
      sel_stats = stats_arr[0];
      sel_outst = outst_arr[0];
      err_any   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_sel == SEL_W'(i)) begin
            sel_stats = stats_arr[i];
            sel_outst = outst_arr[i];
         end
         err_any = err_any | err_arr[i];
      end
   end

   // Field bits above the configured widths are always zero.
   assign unused_sel_bits = ^sel_stats;

   // Registered readout; resets to the channel-0 reset values.
   always_ff @(posedge clk) begin
      if (reset) begin
         in_cnt      <= '0;
         out_cnt     <= '0;
         outstanding <= '0;
         lat_min     <= LAT_NONE_MIN[LAT_W-1:0];
         lat_max     <= '0;
         lat_last    <= '0;
         err         <= '0;
      end else begin
         in_cnt      <= sel_stats.in_cnt[CNT_W-1:0];
         out_cnt     <= sel_stats.out_cnt[CNT_W-1:0];
         outstanding <= sel_outst;
         lat_min     <= sel_stats.lat_min[LAT_W-1:0];
         lat_max     <= sel_stats.lat_max[LAT_W-1:0];
         lat_last    <= sel_stats.lat_last[LAT_W-1:0];
         err         <= err_any;
      end
   end

endmodule

// File: tb/tb_rglib_rotate_stream_monitor.sv
// Bench for rglib_rotate_stream_monitor: a default 4-channel instance checked
// against a latency scoreboard plus fixed expectations, and a narrow
// 1-channel instance (CNT_W=4, LAT_W=4) for saturation and wrap.
module tb_rglib_rotate_stream_monitor;

   localparam int NUM_CH = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // main instance
   logic              reset, clear;
   logic [NUM_CH-1:0] in_valid, in_ready, out_valid, out_ready;
   logic [1:0]        ch_sel;
   logic [31:0]       in_cnt, out_cnt;
   logic [3:0]        outstanding;
   logic [15:0]       lat_min, lat_max, lat_last;
   logic [2:0]        err;
   logic [1:0]        rst_activity;

   // narrow instance
   logic       s_reset, s_clear;
   logic [0:0] s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_ch_sel;
   logic [3:0] s_in_cnt, s_out_cnt, s_outstanding, s_lat_min, s_lat_max, s_lat_last;
   logic [2:0] s_err;
   logic [1:0] s_rst_activity;

   rglib_rotate_stream_monitor #(.NUM_CH(4), .DEPTH(8), .CNT_W(32), .LAT_W(16)) dut (
      .clk(clk), .reset(reset), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
      .ch_sel(ch_sel), .in_cnt(in_cnt), .out_cnt(out_cnt), .outstanding(outstanding),
      .lat_min(lat_min), .lat_max(lat_max), .lat_last(lat_last),
      .err(err), .rst_activity(rst_activity)
   );

   rglib_rotate_stream_monitor #(.NUM_CH(1), .DEPTH(8), .CNT_W(4), .LAT_W(4)) dut_s (
      .clk(clk), .reset(s_reset), .clear(s_clear),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .out_valid(s_out_valid), .out_ready(s_out_ready),
      .ch_sel(s_ch_sel), .in_cnt(s_in_cnt), .out_cnt(s_out_cnt), .outstanding(s_outstanding),
      .lat_min(s_lat_min), .lat_max(s_lat_max), .lat_last(s_lat_last),
      .err(s_err), .rst_activity(s_rst_activity)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Behavioural model of the main instance's latency path.
   int          cyc = 0;
   logic [15:0] m_ts = '0;
   logic [15:0] m_fifo [NUM_CH][$];
   logic [15:0] m_min  [NUM_CH];
   logic [15:0] m_max  [NUM_CH];
   logic [15:0] m_last [NUM_CH];

   typedef struct {
      int          due;
      logic [15:0] last;
      logic [15:0] mn;
      logic [15:0] mx;
   } sb_t;
   sb_t sb_q[$];

   task automatic model_edge();
      logic        ihs, ohs;
      int          pre;
      logic [15:0] lat;
      if (reset) begin
         m_ts = '0;
         for (int c = 0; c < NUM_CH; c++) begin
            m_fifo[c].delete();
            m_min[c] = 16'hFFFF; m_max[c] = '0; m_last[c] = '0;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            ihs = in_valid[c] & in_ready[c];
            ohs = out_valid[c] & out_ready[c];
            pre = m_fifo[c].size();
            if (ohs && pre > 0) begin
               lat = m_ts - m_fifo[c].pop_front();
               if (!clear) begin
                  m_last[c] = lat;
                  if (lat < m_min[c]) m_min[c] = lat;
                  if (lat > m_max[c]) m_max[c] = lat;
                  if (c == int'(ch_sel)) sb_q.push_back('{cyc + 1, m_last[c], m_min[c], m_max[c]});
               end
            end
            if (ihs && (pre < 8 || (ohs && pre > 0))) m_fifo[c].push_back(m_ts);
            if (clear) begin
               m_min[c] = 16'hFFFF; m_max[c] = '0; m_last[c] = '0;
            end
         end
         m_ts = m_ts + 16'd1;
      end
   endtask

   // Compare readout when a scoreboard entry becomes visible.
   always @(negedge clk) begin
      while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
         sb_t e;
         e = sb_q.pop_front();
         check("sb_lat_last", lat_last, e.last);
         check("sb_lat_min", lat_min, e.mn);
         check("sb_lat_max", lat_max, e.mx);
      end
   end

   task automatic step();
      @(posedge clk);
      cyc++;
      model_edge();
      #1;
   endtask

   initial begin
      reset = 1'b1; clear = 1'b0; ch_sel = '0;
      in_valid = '0; in_ready = '0; out_valid = '0; out_ready = '0;
      s_reset = 1'b1; s_clear = 1'b0; s_ch_sel = 1'b1;
      s_in_valid = '0; s_in_ready = '0; s_out_valid = '0; s_out_ready = '0;
      repeat (3) step();
      reset = 1'b0;
      step(); step();

      // reset activity: 4 reset cycles, in_valid[2] only on the 2nd
      reset = 1'b1;
      step();
      in_valid = 4'b0100; step();
      in_valid = '0;      step(); step();
      reset = 1'b0;
      step(); step();
      check("rst_act_in", rst_activity, 2'b01);

      // second reset without valids; readout shows reset values
      reset = 1'b1;
      repeat (3) step();
      check("rst_in_cnt", in_cnt, 0);
      check("rst_out_cnt", out_cnt, 0);
      check("rst_outst", outstanding, 0);
      check("rst_lat_min", lat_min, 16'hFFFF);
      check("rst_lat_max", lat_max, 0);
      check("rst_lat_last", lat_last, 0);
      check("rst_err", err, 0);
      reset = 1'b0;

      // latency on ch1: in at ts 10,11,12; out at ts 15,19,20
      ch_sel = 2'd1; in_ready = '1; out_ready = '1;
      for (int t = 0; t <= 20; t++) begin
         in_valid  = (t >= 10 && t <= 12) ? 4'b0010 : 4'b0000;
         out_valid = (t == 15 || t == 19 || t == 20) ? 4'b0010 : 4'b0000;
         step();
      end
      in_valid = '0; out_valid = '0;
      step(); step();
      check("lat_last", lat_last, 16'd8);
      check("lat_min", lat_min, 16'd5);
      check("lat_max", lat_max, 16'd8);
      check("lat_outst", outstanding, 0);
      check("lat_in_cnt", in_cnt, 3);
      check("lat_out_cnt", out_cnt, 3);
      check("rst_act_none", rst_activity, 2'b00);

      // overflow on ch0: 9 pushes into depth 8, then 8 pops
      ch_sel = 2'd0; in_ready = 4'b0001;
      in_valid = 4'b0001;
      repeat (9) step();
      in_valid = '0;
      step(); step();
      check("ovf_err", err, 3'b010);
      check("ovf_outst", outstanding, 8);
      check("ovf_in_cnt", in_cnt, 9);
      out_valid = 4'b0001;
      repeat (8) step();
      out_valid = '0;
      step(); step();
      check("ovf_no_unf", err, 3'b010);
      check("ovf_drained", outstanding, 0);
      check("ovf_out_cnt", out_cnt, 8);
      check("ovf_lat_last", lat_last, m_last[0]);

      // underflow on ch3: simultaneous in+out while empty
      ch_sel = 2'd3; in_ready = 4'b1000;
      step(); step();
      in_valid = 4'b1000; out_valid = 4'b1000;
      step();
      in_valid = '0; out_valid = '0;
      step(); step();
      check("unf_err", err, 3'b011);
      check("unf_outst", outstanding, 1);
      repeat (3) step();
      out_valid = 4'b1000; step();
      out_valid = '0;
      step(); step();
      check("unf_outst_after", outstanding, 0);
      check("unf_lat", lat_last, 16'd6);

      // retract on ch0, sticky through clear
      ch_sel = 2'd0; out_ready = '0;
      step(); step();
      out_valid = 4'b0001; step();
      out_valid = '0; step(); step(); step();
      check("ret_err", err, 3'b111);
      clear = 1'b1; in_valid = 4'b0001; in_ready = 4'b0001;
      step();
      clear = 1'b0; in_valid = '0;
      step(); step();
      check("clr_err_sticky", err, 3'b111);
      check("clr_in_cnt", in_cnt, 0);
      check("clr_out_cnt", out_cnt, 0);
      check("clr_lat_min", lat_min, 16'hFFFF);
      check("clr_lat_max", lat_max, 0);
      check("clr_lat_last", lat_last, 0);
      check("clr_outst_kept", outstanding, 1);
      reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      step(); step();
      check("reset_err", err, 0);
      check("reset_outst", outstanding, 0);

      // narrow instance: 18-cycle latency wraps to 2; ch_sel=1 maps to ch0
      s_reset = 1'b0;
      s_in_valid = 1'b1; s_in_ready = 1'b1; s_out_ready = 1'b1;
      step();
      s_in_valid = 1'b0;
      repeat (17) step();
      s_out_valid = 1'b1; step();
      s_out_valid = 1'b0;
      step(); step();
      check("s_lat_last", s_lat_last, 4'd2);
      check("s_lat_min", s_lat_min, 4'd2);
      check("s_out_cnt", s_out_cnt, 1);
      check("s_outst0", s_outstanding, 0);
      s_in_valid = 1'b1;
      repeat (20) step();
      s_in_valid = 1'b0;
      step(); step();
      check("s_in_sat", s_in_cnt, 4'hF);
      check("s_outst8", s_outstanding, 8);
      check("s_err_ovf", s_err, 3'b010);
      s_clear = 1'b1; step();
      s_clear = 1'b0;
      step(); step();
      check("s_clr_in", s_in_cnt, 0);
      check("s_clr_out", s_out_cnt, 0);
      check("s_clr_min", s_lat_min, 4'hF);
      check("s_clr_last", s_lat_last, 0);
      check("s_clr_outst", s_outstanding, 8);

      check("sb_drained", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
